cordic_polar_to_rect: RTL and testbench



---
 rtl/cordic_polar_to_rect.sv | 196 +++++++++++++++++++
 tb/tb_cordic_polar_to_rect.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_polar_to_rect.sv
// rtl/cordic_polar_to_rect.sv - pipelined rotation-mode CORDIC, {angle, radius} -> {Q, I}
// Optional input phase_offset added to the angle when CORDIC_PHASE_OFFSET_EN is defined.
`timescale 1ns/1ps
module cordic_polar_to_rect #(
    parameter int NUM_ITERS              = 15,
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int C_M00_AXIS_TDATA_WIDTH = 32
) (
    input  logic                              s00_axis_aclk,
    input  logic                              s00_axis_areset,
`ifdef CORDIC_PHASE_OFFSET_EN
    input  logic [15:0]                       phase_offset,
`endif
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
    input  logic                              s00_axis_tvalid,
    input  logic                              s00_axis_tlast,
    input  logic [3:0]                        s00_axis_tstrb,
    output logic                              s00_axis_tready,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
    output logic                              m00_axis_tvalid,
    output logic                              m00_axis_tlast,
    output logic [3:0]                        m00_axis_tstrb,
    input  logic                              m00_axis_tready
);

    function automatic logic signed [17:0] atan_lut(input int idx);
        case (idx)
            0:       return 18'sd8192;
            1:       return 18'sd4836;
            2:       return 18'sd2555;
            3:       return 18'sd1297;
            4:       return 18'sd651;
            5:       return 18'sd326;
            6:       return 18'sd163;
            7:       return 18'sd81;
            8:       return 18'sd41;
            9:       return 18'sd20;
            10:      return 18'sd10;
            11:      return 18'sd5;
            12:      return 18'sd3;
            default: return 18'sd1;
        endcase
    endfunction

    function automatic logic [15:0] sat16(input logic signed [33:0] v);
        if (v > 34'sd32767)
            return 16'h7FFF;
        else if (v < -34'sd32768)
            return 16'h8000;
        else
            return v[15:0];
    endfunction

    logic en;
    logic m_tvalid_q;

    assign en              = !m_tvalid_q || m00_axis_tready;
    assign s00_axis_tready = en;

    // Per-stage views; meta = {valid, tlast, tstrb[3:0], quadrant[1:0]}
    logic signed [33:0] sx [0:NUM_ITERS];
    logic signed [33:0] sy [0:NUM_ITERS];
    logic signed [17:0] sz [0:NUM_ITERS];
    logic [7:0]         sm [0:NUM_ITERS];

    logic [15:0]        angle;
    logic signed [33:0] p_x_d, p_x_q;
    logic signed [17:0] p_z_d, p_z_q;
    logic [7:0]         p_m_d, p_m_q;

    always_comb begin
`ifdef CORDIC_PHASE_OFFSET_EN
        angle = s00_axis_tdata[31:16] + phase_offset;
`else
        angle = s00_axis_tdata[31:16];
`endif
        p_x_d = p_x_q;
        p_z_d = p_z_q;
        p_m_d = p_m_q;
        if (en) begin
            // 39797 is 1/K in 0.16, so x0 already carries the CORDIC gain compensation
            p_x_d = $signed({18'd0, s00_axis_tdata[15:0]}) * 34'sd39797;
            p_z_d = {4'b0, angle[13:0]};
            p_m_d = {s00_axis_tvalid, s00_axis_tlast, s00_axis_tstrb, angle[15:14]};
        end
    end

    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            p_x_q <= '0;
            p_z_q <= '0;
            p_m_q <= '0;
        end else begin
            p_x_q <= p_x_d;
            p_z_q <= p_z_d;
            p_m_q <= p_m_d;
        end
    end

    assign sx[0] = p_x_q;
    assign sy[0] = '0;
    assign sz[0] = p_z_q;
    assign sm[0] = p_m_q;

    for (genvar i = 0; i < NUM_ITERS; i++) begin : g_stage
        localparam logic signed [17:0] ATAN = atan_lut(i);
        logic signed [33:0] x_d, x_q, y_d, y_q;
        logic signed [17:0] z_d, z_q;
        logic [7:0]         m_d, m_q;

        always_comb begin
            x_d = x_q;
            y_d = y_q;
            z_d = z_q;
            m_d = m_q;
            if (en) begin
                m_d = sm[i];
                if (!sz[i][17]) begin
                    x_d = sx[i] - (sy[i] >>> i);
                    y_d = sy[i] + (sx[i] >>> i);
                    z_d = sz[i] - ATAN;
                end else begin
                    x_d = sx[i] + (sy[i] >>> i);
                    y_d = sy[i] - (sx[i] >>> i);
                    z_d = sz[i] + ATAN;
                end
            end
        end

        always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
            if (s00_axis_areset) begin
                x_q <= '0;
                y_q <= '0;
                z_q <= '0;
                m_q <= '0;
            end else begin
                x_q <= x_d;
                y_q <= y_d;
                z_q <= z_d;
                m_q <= m_d;
            end
        end

        assign sx[i+1] = x_q;
        assign sy[i+1] = y_q;
        assign sz[i+1] = z_q;
        assign sm[i+1] = m_q;
    end

    logic signed [33:0] xr, yr, i_v, q_v;
    logic [31:0]        m_tdata_d, m_tdata_q;
    logic [3:0]         m_tstrb_d, m_tstrb_q;
    logic               m_tvalid_d, m_tlast_d, m_tlast_q;

    always_comb begin
        xr = (sx[NUM_ITERS] + 34'sd32768) >>> 16;
        yr = (sy[NUM_ITERS] + 34'sd32768) >>> 16;
        // Undo the quadrant fold done in stage P; saturation absorbs -(-32768)
        case (sm[NUM_ITERS][1:0])
            2'd0:    begin i_v = xr;  q_v = yr;  end
            2'd1:    begin i_v = -yr; q_v = xr;  end
            2'd2:    begin i_v = -xr; q_v = -yr; end
            default: begin i_v = yr;  q_v = -xr; end
        endcase
        m_tvalid_d = m_tvalid_q;
        m_tlast_d  = m_tlast_q;
        m_tstrb_d  = m_tstrb_q;
        m_tdata_d  = m_tdata_q;
        if (en) begin
            m_tvalid_d = sm[NUM_ITERS][7];
            m_tlast_d  = sm[NUM_ITERS][6];
            m_tstrb_d  = sm[NUM_ITERS][5:2];
            m_tdata_d  = {sat16(q_v), sat16(i_v)};
        end
    end

    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            m_tstrb_q  <= 4'hF;
            m_tdata_q  <= '0;
        end else begin
            m_tvalid_q <= m_tvalid_d;
            m_tlast_q  <= m_tlast_d;
            m_tstrb_q  <= m_tstrb_d;
            m_tdata_q  <= m_tdata_d;
        end
    end

    assign m00_axis_tvalid = m_tvalid_q;
    assign m00_axis_tlast  = m_tlast_q;
    assign m00_axis_tstrb  = m_tstrb_q;
    assign m00_axis_tdata  = m_tdata_q;

endmodule

// File: tb/tb_cordic_polar_to_rect.sv
// tb/tb_cordic_polar_to_rect.sv - scoreboard bench for cordic_polar_to_rect
`timescale 1ns/1ps
module tb_cordic_polar_to_rect;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_tdata;
    logic        s_tvalid, s_tlast, s_tready;
    logic [3:0]  s_tstrb;
    logic [31:0] m_tdata;
    logic        m_tvalid, m_tlast, m_tready;
    logic [3:0]  m_tstrb;
`ifdef CORDIC_PHASE_OFFSET_EN
    logic [15:0] phase_offset;
`endif

    typedef struct {
        int         i_exp;
        int         q_exp;
        int         tol;
        logic       last;
        logic [3:0] strb;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 0;
    bit          bp_done = 0;
    exp_t        mon_e;
    int          ai, aq;
    logic [15:0] po_now;

    always #5 clk = ~clk;

    cordic_polar_to_rect #(.NUM_ITERS(15)) dut (
        .s00_axis_aclk   (clk),
        .s00_axis_areset (rst),
`ifdef CORDIC_PHASE_OFFSET_EN
        .phase_offset    (phase_offset),
`endif
        .s00_axis_tdata  (s_tdata),
        .s00_axis_tvalid (s_tvalid),
        .s00_axis_tlast  (s_tlast),
        .s00_axis_tstrb  (s_tstrb),
        .s00_axis_tready (s_tready),
        .m00_axis_tdata  (m_tdata),
        .m00_axis_tvalid (m_tvalid),
        .m00_axis_tlast  (m_tlast),
        .m00_axis_tstrb  (m_tstrb),
        .m00_axis_tready (m_tready)
    );

    function automatic int ideal(input real v);
        real r;
        r = v;
        if (r > 32767.0)  r = 32767.0;
        if (r < -32768.0) r = -32768.0;
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    endfunction

    function automatic exp_t make_exp(input logic [31:0] d, input logic [15:0] po,
                                      input logic last, input logic [3:0] strb);
        exp_t        e;
        logic [15:0] ang;
        real         th, r;
        ang     = d[31:16] + po;
        th      = real'(ang) * 6.283185307179586 / 65536.0;
        r       = real'(d[15:0]);
        e.i_exp = ideal(r * $cos(th));
        e.q_exp = ideal(r * $sin(th));
        e.tol   = (d[15:0] == 16'd0) ? 0 : ((d[15:0] > 16'd32767) ? 16 : 3);
        e.last  = last;
        e.strb  = strb;
        return e;
    endfunction

    // Scoreboard: push on every accepted beat, pop and compare on every emitted beat
    always @(negedge clk) begin
        #1;
        if (mon_en && !rst) begin
            checks++;
            if (s_tready !== (!m_tvalid || m_tready)) begin
                errors++;
                $display("FAIL s_tready: got %b, want %b", s_tready, (!m_tvalid || m_tready));
            end
            if (m_tvalid && m_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got tdata %h, want no beat", m_tdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    ai = $signed(m_tdata[15:0]);
                    aq = $signed(m_tdata[31:16]);
                    if ((ai - mon_e.i_exp) > mon_e.tol || (mon_e.i_exp - ai) > mon_e.tol) begin
                        errors++;
                        $display("FAIL i_value: got %0d, want %0d +/-%0d", ai, mon_e.i_exp, mon_e.tol);
                    end
                    checks++;
                    if ((aq - mon_e.q_exp) > mon_e.tol || (mon_e.q_exp - aq) > mon_e.tol) begin
                        errors++;
                        $display("FAIL q_value: got %0d, want %0d +/-%0d", aq, mon_e.q_exp, mon_e.tol);
                    end
                    checks++;
                    if (m_tlast !== mon_e.last) begin
                        errors++;
                        $display("FAIL tlast: got %b, want %b", m_tlast, mon_e.last);
                    end
                    checks++;
                    if (m_tstrb !== mon_e.strb) begin
                        errors++;
                        $display("FAIL tstrb: got %h, want %h", m_tstrb, mon_e.strb);
                    end
                end
            end
            if (s_tvalid && s_tready) begin
`ifdef CORDIC_PHASE_OFFSET_EN
                po_now = phase_offset;
`else
                po_now = 16'd0;
`endif
                exp_q.push_back(make_exp(s_tdata, po_now, s_tlast, s_tstrb));
            end
        end
    end

    task automatic send(input logic [15:0] ang, input logic [15:0] rad,
                        input logic last, input logic [3:0] strb);
        int n;
        @(negedge clk);
        s_tvalid = 1'b1;
        s_tdata  = {ang, rad};
        s_tlast  = last;
        s_tstrb  = strb;
        for (n = 0; n < 200; n++) begin
            #1;
            if (s_tready) break;
            @(negedge clk);
        end
        if (n == 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got s_tready 0 for 200 cycles, want 1");
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b, want 0", m_tvalid); end
        checks++;
        if (m_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast: got %b, want 0", m_tlast); end
        checks++;
        if (m_tdata !== 32'h0) begin errors++; $display("FAIL rst_tdata: got %h, want 0", m_tdata); end
        checks++;
        if (m_tstrb !== 4'hF) begin errors++; $display("FAIL rst_tstrb: got %h, want F", m_tstrb); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (s_tready !== 1'b1) begin errors++; $display("FAIL rst_tready: got %b, want 1", s_tready); end
        mon_en = 1;
    endtask

    task automatic test_latency;
        int n;
        m_tready = 1'b1;
        @(negedge clk);
        s_tvalid = 1'b1;
        s_tdata  = {16'h0000, 16'd10000};
        s_tlast  = 1'b0;
        s_tstrb  = 4'h3;
        for (n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            s_tvalid = 1'b0;
            if (m_tvalid) break;
        end
        checks++;
        if (n != 17) begin errors++; $display("FAIL latency: got %0d cycles, want 17", n); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_angles;
        int n;
        m_tready = 1'b1;
        send(16'h4000, 16'd10000, 1'b0, 4'h1);
        send(16'h6000, 16'd20000, 1'b0, 4'h2);
        send(16'h0000, 16'hFFFF,  1'b0, 4'h4);
        send(16'h8000, 16'hFFFF,  1'b0, 4'h8);
        send(16'hFFFF, 16'd10000, 1'b0, 4'h5);
        send(16'h1234, 16'd0,     1'b0, 4'hA);
        send(16'hC000, 16'd32767, 1'b1, 4'hC);
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        for (n = 0; n < 200; n++) begin
            @(negedge clk); #2;
            if (exp_q.size() == 0) break;
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL angles_drain: got %0d pending, want 0", exp_q.size()); end
    endtask

    task automatic test_backpressure;
        bp_done = 0;
        fork
            begin
                int n;
                for (int k = 0; k < 32; k++)
                    send(16'(k * 16'h0800), 16'd1000, (k == 31), 4'(k));
                @(negedge clk);
                s_tvalid = 1'b0;
                s_tlast  = 1'b0;
                for (n = 0; n < 2000; n++) begin
                    @(negedge clk); #2;
                    if (exp_q.size() == 0) break;
                end
                checks++;
                if (exp_q.size() != 0) begin errors++; $display("FAIL bp_drain: got %0d pending, want 0", exp_q.size()); end
                bp_done = 1;
            end
            begin
                while (!bp_done) begin
                    @(negedge clk);
                    m_tready = 1'($urandom_range(0, 1));
                end
            end
        join
        m_tready = 1'b1;
    endtask

    task automatic test_reset_midstream;
        int n;
        m_tready = 1'b0;
        for (int k = 0; k < 12; k++)
            send(16'h9000 + 16'(k * 256), 16'd3000, 1'b0, 4'hF);
        @(negedge clk);
        s_tvalid = 1'b0;
        for (n = 0; n < 100; n++) begin
            if (m_tvalid) break;
            @(negedge clk);
        end
        checks++;
        if (m_tvalid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b, want 1", m_tvalid); end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (m_tvalid !== 1'b0) begin errors++; $display("FAIL mid_tvalid: got %b, want 0", m_tvalid); end
        checks++;
        if (m_tdata !== 32'h0) begin errors++; $display("FAIL mid_tdata: got %h, want 0", m_tdata); end
        checks++;
        if (m_tstrb !== 4'hF) begin errors++; $display("FAIL mid_tstrb: got %h, want F", m_tstrb); end
        exp_q.delete();
        m_tready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send(16'h2000, 16'd7000, 1'b1, 4'h6);
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        for (n = 0; n < 200; n++) begin
            @(negedge clk); #2;
            if (exp_q.size() == 0) break;
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL mid_drain: got %0d pending, want 0", exp_q.size()); end
    endtask

`ifdef CORDIC_PHASE_OFFSET_EN
    task automatic test_phase_offset;
        int n;
        m_tready     = 1'b1;
        phase_offset = 16'h4000;
        send(16'hC000, 16'd5000, 1'b0, 4'h7);
        @(posedge clk);
        #1;
        phase_offset = 16'h1000;
        send(16'h0000, 16'd5000, 1'b1, 4'h9);
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        for (n = 0; n < 200; n++) begin
            @(negedge clk); #2;
            if (exp_q.size() == 0) break;
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL phase_drain: got %0d pending, want 0", exp_q.size()); end
        phase_offset = 16'h0000;
    endtask
`endif

    initial begin
        rst      = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = 32'h0;
        s_tlast  = 1'b0;
        s_tstrb  = 4'h0;
        m_tready = 1'b1;
`ifdef CORDIC_PHASE_OFFSET_EN
        phase_offset = 16'h0000;
`endif
        test_reset();
        test_latency();
        test_angles();
        test_backpressure();
        test_reset_midstream();
`ifdef CORDIC_PHASE_OFFSET_EN
        test_phase_offset();
`endif
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL final_queue: got %0d pending, want 0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
